// File: rtl/track_ctrl.sv
// track_ctrl - line-follower decision stage.
//
// Takes the obstacle distance from the ultrasonic block and the three
// line-sensor bits, and produces the 2-bit drive mode for the motor block.
// Track bits are synchronised (2 flops) and debounced on a slow decision
// tick. A 5-state FSM follows the line, halts on obstacles with a
// clear-path hysteresis, and handles a lost line.
//
// Optional feature macro: TRACK_CTRL_LOST_SEARCH_EN
//   defined   - LOST keeps turning toward the last seen turn direction for
//               LOST_MAX ticks, then stops.
//   undefined - LOST stops immediately (no search counter is built).
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   distance     in   [19:0] obstacle distance in cm, 0 = no echo (ignored)
//   left_track   in   1 = line under left sensor   (asynchronous)
//   mid_track    in   1 = line under middle sensor (asynchronous)
//   right_track  in   1 = line under right sensor  (asynchronous)
//   mode         out  [1:0] 00 STOP, 01 FORWARD, 10 LEFT, 11 RIGHT (registered)
//   state        out  [2:0] 0 BLOCKED, 1 FWD, 2 LEFT, 3 RIGHT, 4 LOST
//   blocked      out  high while in BLOCKED (registered)
module track_ctrl #(
  parameter int SAMPLE_DIV   = 100000,
  parameter int FILT_LEN     = 4,
  parameter int STOP_CM      = 20,
  parameter int GO_CM        = 25,
  parameter int RESUME_TICKS = 50,
  parameter int LOST_MAX     = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] distance,
  input  logic        left_track,
  input  logic        mid_track,
  input  logic        right_track,
  output logic [1:0]  mode,
  output logic [2:0]  state,
  output logic        blocked
);

  typedef enum logic [2:0] {
    ST_BLOCKED = 3'd0,
    ST_FWD     = 3'd1,
    ST_LEFT    = 3'd2,
    ST_RIGHT   = 3'd3,
    ST_LOST    = 3'd4
  } state_e;

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int AGR_W = $clog2(FILT_LEN + 1);
  localparam int CLR_W = $clog2(RESUME_TICKS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [AGR_W-1:0] AGR_MAX  = AGR_W'(FILT_LEN);
  localparam logic [CLR_W-1:0] CLR_MAX  = CLR_W'(RESUME_TICKS);
  localparam logic [19:0]      STOP_V   = 20'(STOP_CM);
  localparam logic [19:0]      GO_V     = 20'(GO_CM);

  localparam logic [1:0] MODE_STOP  = 2'b00;
  localparam logic [1:0] MODE_FWD   = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_RIGHT = 2'b11;

`ifdef TRACK_CTRL_LOST_SEARCH_EN
  localparam int LOST_W = $clog2(LOST_MAX + 1);
  localparam logic [LOST_W-1:0] LOST_V = LOST_W'(LOST_MAX);
`endif

  // Map a filtered track vector {L,M,R} to a steering state; 101 holds.
  function automatic state_e decode(input logic [2:0] v, input state_e hold);
    state_e r;
    case (v)
      3'b010, 3'b111: r = ST_FWD;
      3'b100, 3'b110: r = ST_LEFT;
      3'b001, 3'b011: r = ST_RIGHT;
      3'b000:         r = ST_LOST;
      3'b101:         r = hold;
      default:        r = hold;
    endcase
    return r;
  endfunction

  logic [2:0]       sync1_q, sync2_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic [2:0]       samp_q, samp_d;
  logic [2:0]       filt_q, filt_d;
  logic [AGR_W-1:0] agree_q, agree_d;
  logic [CLR_W-1:0] clr_q, clr_d;
  state_e           st_q, st_d, dec;
  logic [1:0]       mode_q, mode_d;
  logic             blocked_q, blocked_d;
  logic             obstacle, clear_path;
`ifdef TRACK_CTRL_LOST_SEARCH_EN
  logic [LOST_W-1:0] lost_q, lost_d;
  logic              last_dir_q, last_dir_d;   // 0 = LEFT, 1 = RIGHT
`endif

  // Decision tick: one-cycle pulse every SAMPLE_DIV clocks.
  always_comb begin
    tick = (div_q == DIV_LAST);
    if (tick) begin
      div_d = DIV_W'(0);
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Debounce filter: accept the sampled vector after FILT_LEN equal ticks.
  always_comb begin
    samp_d  = samp_q;
    agree_d = agree_q;
    filt_d  = filt_q;
    if (tick) begin
      samp_d = sync2_q;
      if (sync2_q == samp_q) begin
        agree_d = (agree_q < AGR_MAX) ? agree_q + AGR_W'(1) : agree_q;
      end else begin
        agree_d = AGR_W'(1);
      end
      // The FSM below decodes filt_d, so an accepted vector acts this tick.
      if (agree_d == AGR_MAX) begin
        filt_d = sync2_q;
      end else begin
        filt_d = filt_q;
      end
    end else begin
      samp_d = samp_q;
    end
  end

  // Steering FSM next state and its counters.
  always_comb begin
    st_d       = st_q;
    clr_d      = clr_q;
`ifdef TRACK_CTRL_LOST_SEARCH_EN
    lost_d     = lost_q;
    last_dir_d = last_dir_q;
`endif
    obstacle   = (distance != 20'd0) && (distance < STOP_V);
    clear_path = (distance != 20'd0) && (distance >= GO_V);
    dec        = decode(filt_d, st_q);

    if (tick) begin
      if (obstacle) begin
        st_d  = ST_BLOCKED;
        clr_d = CLR_W'(0);
      end else begin
        case (st_q)
          ST_BLOCKED: begin
            // distance 0 (no echo) leaves the clear count untouched
            if (distance == 20'd0) begin
              clr_d = clr_q;
            end else if (clear_path) begin
              clr_d = (clr_q < CLR_MAX) ? clr_q + CLR_W'(1) : clr_q;
            end else begin
              clr_d = CLR_W'(0);
            end
            if (clr_d >= CLR_MAX) begin
              // decode holds BLOCKED on 101; resume straight ahead then
              st_d  = (dec == ST_BLOCKED) ? ST_FWD : dec;
              clr_d = CLR_W'(0);
            end else begin
              st_d = ST_BLOCKED;
            end
          end
          ST_FWD, ST_LEFT, ST_RIGHT: begin
            st_d = dec;
          end
          ST_LOST: begin
            if (filt_d != 3'b000) begin
              st_d = (dec == ST_LOST) ? ST_FWD : dec;
            end else begin
              st_d = ST_LOST;
`ifdef TRACK_CTRL_LOST_SEARCH_EN
              lost_d = (lost_q < LOST_V) ? lost_q + LOST_W'(1) : lost_q;
`endif
            end
          end
          default: begin
            st_d = ST_BLOCKED;
          end
        endcase
      end
    end else begin
      st_d = st_q;
    end

`ifdef TRACK_CTRL_LOST_SEARCH_EN
    if ((st_d == ST_LOST) && (st_q != ST_LOST)) begin
      lost_d = LOST_W'(0);
    end else begin
      lost_d = lost_d;
    end
    if (st_d == ST_LEFT) begin
      last_dir_d = 1'b0;
    end else if (st_d == ST_RIGHT) begin
      last_dir_d = 1'b1;
    end else begin
      last_dir_d = last_dir_q;
    end
`endif
  end

  // Output decode from the next state, registered with the state.
  always_comb begin
    blocked_d = (st_d == ST_BLOCKED);
    case (st_d)
      ST_BLOCKED: mode_d = MODE_STOP;
      ST_FWD:     mode_d = MODE_FWD;
      ST_LEFT:    mode_d = MODE_LEFT;
      ST_RIGHT:   mode_d = MODE_RIGHT;
`ifdef TRACK_CTRL_LOST_SEARCH_EN
      ST_LOST:    mode_d = (lost_d < LOST_V) ?
                           (last_dir_d ? MODE_RIGHT : MODE_LEFT) : MODE_STOP;
`else
      ST_LOST:    mode_d = MODE_STOP;
`endif
      default:    mode_d = MODE_STOP;
    endcase
  end

  // All state registers, asynchronously reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 3'b000;
      sync2_q    <= 3'b000;
      div_q      <= DIV_W'(0);
      samp_q     <= 3'b000;
      filt_q     <= 3'b000;
      agree_q    <= AGR_W'(0);
      clr_q      <= CLR_W'(0);
      st_q       <= ST_BLOCKED;
      mode_q     <= MODE_STOP;
      blocked_q  <= 1'b1;
`ifdef TRACK_CTRL_LOST_SEARCH_EN
      lost_q     <= LOST_W'(0);
      last_dir_q <= 1'b0;
`endif
    end else begin
      sync1_q    <= {left_track, mid_track, right_track};
      sync2_q    <= sync1_q;
      div_q      <= div_d;
      samp_q     <= samp_d;
      filt_q     <= filt_d;
      agree_q    <= agree_d;
      clr_q      <= clr_d;
      st_q       <= st_d;
      mode_q     <= mode_d;
      blocked_q  <= blocked_d;
`ifdef TRACK_CTRL_LOST_SEARCH_EN
      lost_q     <= lost_d;
      last_dir_q <= last_dir_d;
`endif
    end
  end

  assign mode    = mode_q;
  assign state   = st_q;
  assign blocked = blocked_q;

endmodule

// File: tb/tb_track_ctrl.sv
// Self-checking bench for track_ctrl with SAMPLE_DIV=4, FILT_LEN=2,
// RESUME_TICKS=3, LOST_MAX=5. Expected {mode,state,blocked} words are pushed
// to a scoreboard queue as each tick's stimulus is applied and popped once
// the DUT has updated after that tick.
module tb_track_ctrl;
  localparam int SD = 4;

`ifdef TRACK_CTRL_LOST_SEARCH_EN
  localparam logic [1:0] LOST_MODE = 2'b11;
`else
  localparam logic [1:0] LOST_MODE = 2'b00;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] distance = 20'd0;
  logic        lt = 1'b0, mt = 1'b0, rt = 1'b0;
  logic [1:0]  mode;
  logic [2:0]  state;
  logic        blocked;

  int total = 0;
  int bad   = 0;
  logic [5:0] sb_q[$];

  always #5 clk = ~clk;

  track_ctrl #(
    .SAMPLE_DIV(4), .FILT_LEN(2), .STOP_CM(20), .GO_CM(25),
    .RESUME_TICKS(3), .LOST_MAX(5)
  ) dut (
    .clk(clk), .rst(rst), .distance(distance),
    .left_track(lt), .mid_track(mt), .right_track(rt),
    .mode(mode), .state(state), .blocked(blocked)
  );

  function automatic logic [5:0] exp_of(input logic [1:0] m, input logic [2:0] s);
    return {m, s, (s == 3'd0)};
  endfunction

  task automatic set_track(input logic [2:0] v);
    {lt, mt, rt} = v;
  endtask

  // Advance one decision tick; sample 1 time unit after the updating edge.
  task automatic tick();
    repeat (SD) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] m[3] = '{2'b00, 2'b00, 2'b01};
    logic [2:0] s[3] = '{3'd0, 3'd0, 3'd1};
    logic [5:0] e;
    rst = 1'b0;
    distance = 20'd100;
    set_track(3'b010);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({mode, state, blocked} !== 6'b00_000_1) begin
      bad++;
      $display("FAIL reset_state: mode=%b state=%0d blocked=%b, expected 00 0 1",
               mode, state, blocked);
    end
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(exp_of(m[i], s[i]));
      tick();
      e = sb_q.pop_front();
      total++;
      if ({mode, state, blocked} !== e) begin
        bad++;
        $display("FAIL resume[%0d]: mode=%b state=%0d blocked=%b, expected mode=%b state=%0d blocked=%b",
                 i, mode, state, blocked, e[5:4], e[3:1], e[0]);
      end
    end
  endtask

  task automatic test_obstacle();
    logic [19:0] d[15] = '{20'd15, 20'd22, 20'd22, 20'd22, 20'd22, 20'd22,
                           20'd30, 20'd30, 20'd30, 20'd20, 20'd19,
                           20'd25, 20'd25, 20'd0, 20'd25};
    logic [1:0]  m[15] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                           2'b00, 2'b00, 2'b01, 2'b01, 2'b00,
                           2'b00, 2'b00, 2'b00, 2'b01};
    logic [5:0] e;
    for (int i = 0; i < 15; i++) begin
      distance = d[i];
      sb_q.push_back(exp_of(m[i], (m[i] == 2'b01) ? 3'd1 : 3'd0));
      tick();
      e = sb_q.pop_front();
      total++;
      if ({mode, state, blocked} !== e) begin
        bad++;
        $display("FAIL obstacle[%0d] dist=%0d: mode=%b state=%0d blocked=%b, expected mode=%b state=%0d blocked=%b",
                 i, d[i], mode, state, blocked, e[5:4], e[3:1], e[0]);
      end
    end
  endtask

  task automatic test_invalid_distance();
    logic [5:0] e;
    distance = 20'd0;
    for (int i = 0; i < 10; i++) begin
      sb_q.push_back(exp_of(2'b01, 3'd1));
      tick();
      e = sb_q.pop_front();
      total++;
      if ({mode, state, blocked} !== e) begin
        bad++;
        $display("FAIL invalid_dist[%0d]: mode=%b state=%0d blocked=%b, expected mode=%b state=%0d blocked=%b",
                 i, mode, state, blocked, e[5:4], e[3:1], e[0]);
      end
    end
  endtask

  task automatic test_turn();
    logic [2:0] t[6] = '{3'b100, 3'b010, 3'b110, 3'b110, 3'b011, 3'b011};
    logic [1:0] m[6] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11};
    logic [2:0] s[6] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3};
    logic [5:0] e;
    distance = 20'd100;
    for (int i = 0; i < 6; i++) begin
      set_track(t[i]);
      sb_q.push_back(exp_of(m[i], s[i]));
      tick();
      e = sb_q.pop_front();
      total++;
      if ({mode, state, blocked} !== e) begin
        bad++;
        $display("FAIL turn[%0d] track=%b: mode=%b state=%0d blocked=%b, expected mode=%b state=%0d blocked=%b",
                 i, t[i], mode, state, blocked, e[5:4], e[3:1], e[0]);
      end
    end
  endtask

  task automatic test_lost();
    logic [2:0] t[9] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                         3'b000, 3'b010, 3'b010};
    logic [1:0] m[9] = '{2'b11, LOST_MODE, LOST_MODE, LOST_MODE, LOST_MODE,
                         LOST_MODE, 2'b00, 2'b00, 2'b01};
    logic [2:0] s[9] = '{3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd1};
    logic [5:0] e;
    for (int i = 0; i < 9; i++) begin
      set_track(t[i]);
      sb_q.push_back(exp_of(m[i], s[i]));
      tick();
      e = sb_q.pop_front();
      total++;
      if ({mode, state, blocked} !== e) begin
        bad++;
        $display("FAIL lost[%0d] track=%b: mode=%b state=%0d blocked=%b, expected mode=%b state=%0d blocked=%b",
                 i, t[i], mode, state, blocked, e[5:4], e[3:1], e[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] m[3] = '{2'b00, 2'b00, 2'b01};
    logic [2:0] s[3] = '{3'd0, 3'd0, 3'd1};
    logic [5:0] e;
    // assert reset between clock edges and look before any further edge
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({mode, state, blocked} !== 6'b00_000_1) begin
      bad++;
      $display("FAIL async_reset: mode=%b state=%0d blocked=%b, expected 00 0 1",
               mode, state, blocked);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(exp_of(m[i], s[i]));
      tick();
      e = sb_q.pop_front();
      total++;
      if ({mode, state, blocked} !== e) begin
        bad++;
        $display("FAIL rerun[%0d]: mode=%b state=%0d blocked=%b, expected mode=%b state=%0d blocked=%b",
                 i, mode, state, blocked, e[5:4], e[3:1], e[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_obstacle();
    test_invalid_distance();
    test_turn();
    test_lost();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/track_ctrl.md
# track_ctrl

Decision stage between the sensors and the motor driver: consumes `distance` from the ultrasonic block and the three track-sensor bits, and produces the 2-bit `mode` word the motor block turns into PWM and direction pins. Track inputs are synchronised and debounced. A 5-state FSM steers along the line, halts on obstacles with hysteresis, and runs a bounded search when the line is lost.

## Interface
- `SAMPLE_DIV`, 100000: clocks per decision tick (1 ms at 100 MHz).
- `FILT_LEN`, 4: consecutive identical tick samples needed to accept a new track vector.
- `STOP_CM`, 20: stop when `distance < STOP_CM`.
- `GO_CM`, 25: clear-path threshold, `distance >= GO_CM`.
- `RESUME_TICKS`, 50: consecutive clear ticks needed to leave BLOCKED.
- `LOST_MAX`, 500: search ticks before giving up.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `distance` in 20: obstacle distance in cm from the ultrasonic stage. Value 0 means no echo (invalid).
- `left_track`, `mid_track`, `right_track` in 1 each: 1 means line detected. Asynchronous to `clk`.
- `mode` out 2: 00 STOP, 01 FORWARD, 10 LEFT, 11 RIGHT. Registered.
- `state` out 3: debug encoding. 0 BLOCKED, 1 FWD, 2 LEFT, 3 RIGHT, 4 LOST.
- `blocked` out 1: high while state is BLOCKED.

## Operation
- **Synchroniser:** each track bit passes through 2 flops. Vector `raw = {L,M,R}`.
- **Tick generator:** counter 0..SAMPLE_DIV-1. `tick` is high for one cycle when the count is SAMPLE_DIV-1, then the counter wraps. All FSM, filter and counter updates occur only on tick cycles.
- **Filter:**
  - On each tick, if `raw` equals the previous tick's sample, `agree` increments, saturating at FILT_LEN. Otherwise `agree` = 1.
  - When `agree` reaches FILT_LEN, `filt <= raw`.
- **Decode of `filt`:**
  - 010 or 111: FWD.
  - 100 or 110: LEFT.
  - 001 or 011: RIGHT.
  - 101: hold current state.
  - 000: LOST.
- **Last turn:** `last_dir` records the most recent LEFT or RIGHT entered. Reset value LEFT.
- **FSM, evaluated in priority order per tick:**
  - Valid `distance` (nonzero) and `< STOP_CM`, from any state: go to BLOCKED, `clr_cnt` = 0.
  - In BLOCKED:
    - `distance >= GO_CM`: `clr_cnt` increments.
    - `distance` between STOP_CM and GO_CM-1: `clr_cnt` = 0.
    - When `clr_cnt` reaches RESUME_TICKS, go to the decoded state. A 101 pattern maps to FWD here.
  - FWD, LEFT, RIGHT: go to the decoded state. Entering LOST clears `lost_cnt`.
  - In LOST:
    - Any non-000 `filt`: go to the decoded state.
    - Otherwise `lost_cnt` increments, saturating at LOST_MAX.
- **Invalid distance:** `distance == 0` is ignored. It never triggers BLOCKED and never changes `clr_cnt`.
- **`mode` by state:**
  - BLOCKED: 00.
  - FWD: 01.
  - LEFT: 10.
  - RIGHT: 11.
  - LOST: see Configuration.

## Timing
- **Reset values:** `mode`=00, `state`=0 (BLOCKED), `blocked`=1, `filt`=000, `agree`=0, tick counter 0, `clr_cnt`=0, `lost_cnt`=0, `last_dir`=LEFT, synchroniser flops 0.
- **First tick:** first `tick` occurs SAMPLE_DIV cycles after `rst` deasserts.
- **Update timing:** `state`, `mode` and `blocked` update at the clock edge ending the tick cycle, i.e. 1 cycle after the tick.
- **Track input latency:** a stable track change appears on `mode` no sooner than 2 sync cycles plus FILT_LEN ticks.
- **Obstacle latency:** reaction takes 1 tick, with no filtering on `distance`.
- **Simultaneous events:** if an obstacle and a track change arrive on the same tick, the obstacle wins.
- **Mid-operation reset:** an asynchronous `rst` assertion forces all reset values immediately, with no clock required.

## Configuration
- `TRACK_CTRL_LOST_SEARCH_EN`:
  - **Defined:** LOST outputs `mode` = `last_dir` (10 or 11) while `lost_cnt < LOST_MAX`, then 00 once LOST_MAX is reached.
  - **Undefined:** LOST outputs 00 immediately, and `lost_cnt` logic is removed.
  - Both builds: recovery to a line still occurs on any non-000 `filt`.

## Test plan
Bench parameters: SAMPLE_DIV=4, FILT_LEN=2, RESUME_TICKS=3, LOST_MAX=5.

1. **Reset, then resume:** release reset with `distance`=100 and track 010 -> `mode` stays 00 for ticks 1-2, becomes 01 after tick 3. `blocked` drops on the same edge.
2. **Obstacle and hysteresis:** in FWD, drive `distance`=15 -> `mode`=00 after the next tick. Then `distance`=22 for 5 ticks -> remains 00. Then 30 for 3 ticks -> 01.
3. **Invalid distance:** `distance`=0 in FWD for 10 ticks -> `mode` stays 01 and `state` stays 1.
4. **Turn and debounce:** single-tick glitch 100 then back to 010 -> `mode` stays 01. Stable 110 for 2 ticks -> `mode`=10.
5. **Lost line with `TRACK_CTRL_LOST_SEARCH_EN`:** from RIGHT, track 000 -> `mode`=11 for 5 ticks, then 00. Track 010 then returns -> 01 after 2 ticks.
6. **Lost line without the macro, plus async reset:** track 000 -> `mode`=00 immediately after filter acceptance. Assert `rst` mid-tick -> `mode`=00 and `state`=0 without a clock edge.
